// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the external byte-bus controller.
// State codes and the IO address window.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MC_IDLE   = 3'd0,
    MC_IREAD  = 3'd1,
    MC_DREAD  = 3'd2,
    MC_DWRITE = 3'd3,
    MC_COOL   = 3'd4
  } mc_state_t;

  localparam int IO_RANGE_HI = 17;
  localparam int IO_RANGE_LO = 16;

  localparam logic [1:0] LEN_WORD = 2'd3;

endpackage

// File: rtl/mem_ctrl.sv
// Owner of the 8-bit RAM/IO bus: serialises icache refills and
// LSB loads/stores into little-endian byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              instr_in_enable,
  input  logic [ADDR_W-1:0] instr_in_addr,
  output logic              instr_in_valid,
  output logic [31:0]       instr_in,
  input  logic              clr,
  input  logic              lsb_enable,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_len,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata
);

  mc_state_t         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        dout_q, dout_d;
  logic              ivalid_q, ivalid_d;
  logic [31:0]       instr_q, instr_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              io_blocked;
  logic [2:0]        idx;

  assign io_blocked = lsb_enable && lsb_wr && io_buffer_full
                   && (lsb_addr[IO_RANGE_HI:IO_RANGE_LO] == IO_HI);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    mem_a_d  = mem_a_q;
    dout_d   = dout_q;
    ivalid_d = 1'b0;
    instr_d  = instr_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    idx      = cnt_q - 3'd2;
    unique case (state_q)
      MC_IDLE: begin
        // A blocked IO store still owns the bus so ordering is kept
        if (lsb_enable) begin
          if (!io_blocked) begin
            addr_d  = lsb_addr;
            len_d   = lsb_len;
            wdata_d = lsb_wdata;
            data_d  = '0;
            mem_a_d = lsb_addr;
            cnt_d   = 3'd1;
            if (lsb_wr) begin
              state_d = MC_DWRITE;
              dout_d  = lsb_wdata[7:0];
            end else begin
              state_d = MC_DREAD;
            end
          end
        end else if (instr_in_enable && !clr) begin
          addr_d  = instr_in_addr;
          len_d   = LEN_WORD;
          data_d  = '0;
          mem_a_d = instr_in_addr;
          cnt_d   = 3'd1;
          state_d = MC_IREAD;
        end
      end
      MC_IREAD, MC_DREAD: begin
        if (state_q == MC_IREAD && clr) begin
          state_d = MC_COOL;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q <= {1'b0, len_q})
            mem_a_d = addr_q + ADDR_W'(cnt_q);
          // RAM data trails its address by two edges
          if (cnt_q >= 3'd2) begin
            data_d[{idx[1:0], 3'b000} +: 8] = mem_din;
            if (idx == {1'b0, len_q}) begin
              state_d = MC_COOL;
              if (state_q == MC_IREAD) begin
                instr_d  = data_d;
                ivalid_d = 1'b1;
              end else begin
                rdata_d = data_d;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      MC_DWRITE: begin
        if (cnt_q > {1'b0, len_q}) begin
          state_d = MC_COOL;
          done_d  = 1'b1;
        end else begin
          mem_a_d = addr_q + ADDR_W'(cnt_q);
          dout_d  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d   = cnt_q + 3'd1;
        end
      end
      MC_COOL: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MC_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      mem_a_q  <= '0;
      dout_q   <= '0;
      ivalid_q <= 1'b0;
      instr_q  <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      mem_a_q  <= mem_a_d;
      dout_q   <= dout_d;
      ivalid_q <= ivalid_d;
      instr_q  <= instr_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  // Gating with rdy keeps a frozen byte from being written twice
  assign mem_wr = rdy && (state_q == MC_DWRITE);

  assign mem_a          = mem_a_q;
  assign mem_dout       = dout_q;
  assign instr_in_valid = ivalid_q;
  assign instr_in       = instr_q;
  assign lsb_done       = done_q;
  assign lsb_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a byte RAM model.
// Expected bus writes and pulses are queued with their cycle.
module tb_mem_ctrl;

  localparam int K_WR = 0;
  localparam int K_IV = 1;
  localparam int K_LD = 2;
  localparam int K_SD = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [31:0] addr;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        instr_in_enable, instr_in_valid;
  logic [31:0] instr_in_addr, instr_in;
  logic        clr, lsb_enable, lsb_wr, lsb_done;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0;
  ev_t q[$];
  logic [7:0] ram [logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .instr_in_enable(instr_in_enable),
    .instr_in_addr(instr_in_addr),
    .instr_in_valid(instr_in_valid),
    .instr_in(instr_in), .clr(clr),
    .lsb_enable(lsb_enable), .lsb_wr(lsb_wr),
    .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
    .lsb_rdata(lsb_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(int k, logic [31:0] v, logic [31:0] a, int c);
    ev_t e;
    e.kind = k; e.val = v; e.addr = a; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic mon(int k, logic [31:0] v, logic [31:0] a);
    ev_t e;
    bit ok;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected event kind=%0d val=%h addr=%h cyc=%0d, want none",
               k, v, a, cyc);
      return;
    end
    e = q.pop_front();
    ok = (e.kind == k) || (k == K_LD && e.kind == K_SD);
    ok = ok && (e.cyc == cyc);
    ok = ok && (e.kind == K_SD || v === e.val);
    ok = ok && (k != K_WR || a === e.addr);
    if (!ok) begin
      bad++;
      $display("FAIL event: got kind=%0d val=%h addr=%h cyc=%0d want kind=%0d val=%h addr=%h cyc=%0d",
               k, v, a, cyc, e.kind, e.val, e.addr, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr) mon(K_WR, {24'h0, mem_dout}, mem_a);
      if (instr_in_valid) mon(K_IV, instr_in, 32'h0);
      if (lsb_done) mon(K_LD, lsb_rdata, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " mem_a"}, mem_a, 32'h0);
    chk({tag, " mem_dout"}, {24'h0, mem_dout}, 32'h0);
    chk({tag, " mem_wr"}, {31'h0, mem_wr}, 32'h0);
    chk({tag, " ivalid"}, {31'h0, instr_in_valid}, 32'h0);
    chk({tag, " instr_in"}, instr_in, 32'h0);
    chk({tag, " lsb_done"}, {31'h0, lsb_done}, 32'h0);
    chk({tag, " lsb_rdata"}, lsb_rdata, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    instr_in_enable = 1'b0; instr_in_addr = '0; clr = 1'b0;
    lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_len = '0;
    lsb_addr = '0; lsb_wdata = '0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
    ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h0] = 8'h37; ram[32'h1] = 8'h12;
    ram[32'h2] = 8'h00; ram[32'h3] = 8'h00;
    ram[32'h40] = 8'h80;
    ticks(2);
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // icache refill of 0x1000
    instr_in_enable = 1'b1; instr_in_addr = 32'h1000;
    tick(); c0 = cyc;
    push(K_IV, 32'h00000513, 0, c0 + 5);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("refill mem_a[%0d]", k), mem_a, 32'h1000 + k);
      tick();
    end
    ticks(2);
    instr_in_enable = 1'b0;
    tick();

    // 2-byte store
    lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd1;
    lsb_addr = 32'h2002; lsb_wdata = 32'h0000BEEF;
    tick(); c0 = cyc;
    push(K_WR, 32'hEF, 32'h2002, c0);
    push(K_WR, 32'hBE, 32'h2003, c0 + 1);
    push(K_SD, 0, 0, c0 + 2);
    ticks(3);
    lsb_enable = 1'b0;
    tick();
    chk("ram 2002", {24'h0, ram[32'h2002]}, 32'hEF);
    chk("ram 2003", {24'h0, ram[32'h2003]}, 32'hBE);

    // simultaneous icache + 1-byte load: LSB first
    instr_in_enable = 1'b1; instr_in_addr = 32'h0;
    lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0;
    lsb_addr = 32'h40;
    tick(); c0 = cyc;
    push(K_LD, 32'h00000080, 0, c0 + 2);
    push(K_IV, 32'h00001237, 0, c0 + 9);
    ticks(3);
    lsb_enable = 1'b0;
    ticks(7);
    instr_in_enable = 1'b0;
    tick();

    // IO store held off by io_buffer_full, icache waits behind it
    io_buffer_full = 1'b1;
    lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0;
    lsb_addr = 32'h00030000; lsb_wdata = 32'h0000005A;
    instr_in_enable = 1'b1; instr_in_addr = 32'h1000;
    ticks(5);
    io_buffer_full = 1'b0;
    tick(); c0 = cyc;
    push(K_WR, 32'h5A, 32'h00030000, c0);
    push(K_SD, 0, 0, c0 + 1);
    push(K_IV, 32'h00000513, 0, c0 + 8);
    ticks(2);
    lsb_enable = 1'b0;
    ticks(7);
    instr_in_enable = 1'b0;
    tick();

    // clr aborts a refill; clr in IDLE masks the next request
    instr_in_enable = 1'b1; instr_in_addr = 32'h1000;
    tick(); c0 = cyc;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0; instr_in_enable = 1'b0;
    tick();
    clr = 1'b1; instr_in_enable = 1'b1; instr_in_addr = 32'h0;
    tick();
    clr = 1'b0;
    push(K_IV, 32'h00001237, 0, c0 + 10);
    ticks(7);
    instr_in_enable = 1'b0;
    tick();

    // rdy stall mid 4-byte store
    lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd3;
    lsb_addr = 32'h500; lsb_wdata = 32'hCAFEF00D;
    tick(); c0 = cyc;
    push(K_WR, 32'h0D, 32'h500, c0);
    push(K_WR, 32'hF0, 32'h501, c0 + 1);
    push(K_WR, 32'hFE, 32'h502, c0 + 5);
    push(K_WR, 32'hCA, 32'h503, c0 + 6);
    push(K_SD, 0, 0, c0 + 7);
    ticks(2);
    rdy = 1'b0;
    ticks(3);
    rdy = 1'b1;
    ticks(3);
    lsb_enable = 1'b0;
    tick();
    chk("ram 500", {24'h0, ram[32'h500]}, 32'h0D);
    chk("ram 501", {24'h0, ram[32'h501]}, 32'hF0);
    chk("ram 502", {24'h0, ram[32'h502]}, 32'hFE);
    chk("ram 503", {24'h0, ram[32'h503]}, 32'hCA);
    tick();

    // reset in the middle of a refill
    instr_in_enable = 1'b1; instr_in_addr = 32'h1000;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0; instr_in_enable = 1'b0;
    chk_zero("midrst");
    ticks(8);

    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("queue drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single owner of the 8-bit external RAM/IO bus.
- Sits directly upstream of the instruction cache. It serves icache miss refills (32-bit word) and load/store-buffer (LSB) accesses of 1, 2 or 4 bytes.
- Each access is split into sequential byte transfers, little-endian. Data accesses take priority over instruction refills.

Parameters:
- ADDR_W, 32, address width on all request ports and mem_a.
- IO_HI, 2'b11, value of addr[17:16] that marks memory-mapped IO.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state is frozen
- mem_din  in  8  RAM read byte; valid one cycle after its address is on mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  write strobe (1 = write)
- io_buffer_full  in  1  IO sink cannot accept a write this cycle
- instr_in_enable  in  1  icache refill request (level)
- instr_in_addr  in  32  refill word address
- instr_in_valid  out  1  one-cycle refill-complete pulse
- instr_in  out  32  refill word
- clr  in  1  abort an in-flight instruction refill (mispredict flush)
- lsb_enable  in  1  data request (level)
- lsb_wr  in  1  1 = store, 0 = load
- lsb_len  in  2  bytes minus 1: 0 = 1 B, 1 = 2 B, 3 = 4 B
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data, LSB-aligned
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-extended; sign extension is done by the LSB

Behaviour:
- Reset: state = IDLE; mem_a = 0, mem_dout = 0, mem_wr = 0, instr_in_valid = 0, instr_in = 0, lsb_done = 0, lsb_rdata = 0, byte counter = 0.
- Reset mid-access abandons the access; no done or valid pulse follows.
- rdy low: registers hold. mem_wr is gated combinationally to 0 so no byte is written twice.
- States: IDLE, IREAD, DREAD, DWRITE, COOL.
- IDLE acceptance:
  - At a clock edge, lsb_enable is checked first. If lsb_wr=1 and lsb_addr[17:16]==IO_HI and io_buffer_full=1, the store is not accepted that edge. The controller stays in IDLE; a pending icache request is not served over it, to preserve ordering.
  - Otherwise instr_in_enable leads to IREAD.
  - The accepting edge latches addr, len (IREAD uses len 3) and wdata.
- Read (IREAD/DREAD), with the acceptance edge as E0:
  - mem_a = addr+k during the cycle after edge E(k), for k = 0..len.
  - Byte k is sampled from mem_din at edge E(k+2) into bits [8k+7:8k].
  - At the edge that samples the last byte, the assembled word is registered. The matching valid/done pulse is high for exactly the following cycle.
  - A 4-byte read from E0 has its pulse high between E5 and E6.
- Write (DWRITE): mem_wr=1, mem_a=addr+k and mem_dout=wdata[8k+7:8k] for one cycle each, k = 0..len. lsb_done pulses in the cycle after the last byte. A 4-byte store from E0 writes during cycles E0-E1 … E3-E4 and pulses done between E4 and E5.
- Address arithmetic: addr+k wraps modulo 2^32. No alignment checks are made; the LSB guarantees alignment.
- COOL: entered from every state on completion, held for one cycle, all requests ignored. This covers the requester dropping its level request one edge after the pulse. Next state IDLE.
- mem_wr = 0 in every state except DWRITE.
- clr:
  - In IREAD: the controller goes to COOL at the next edge and suppresses instr_in_valid.
  - In IDLE: a same-edge instr_in_enable is ignored.
  - No effect on DREAD or DWRITE.
- Simultaneous icache and LSB requests in IDLE: LSB is served; the icache request stays pending.

Decomposition:
- Add to const.v: state encodings MC_IDLE/MC_IREAD/MC_DREAD/MC_DWRITE/MC_COOL, and macro IO_RANGE 17:16.
- No sub-module. The byte assembler and counter stay inline.

Test Plan:
- Icache refill, addr 0x1000, RAM bytes 13 05 00 00 → instr_in = 0x00000513, pulse between E5 and E6, mem_a sequence 1000..1003.
- LSB store len=1, addr 0x2002, wdata 0xBEEF → writes EF@2002 then BE@2003, mem_wr high for exactly 2 cycles, lsb_done between E2 and E3.
- Same-edge icache 0x0 and LSB load len=0 from 0x40 holding 0x80 → lsb_rdata = 0x00000080 first; icache refill begins after COOL.
- Store to 0x30000 with io_buffer_full=1 for 5 cycles → mem_wr stays 0 during that time. Write issues the edge after full drops; icache request is not served meanwhile.
- clr asserted at E2 of a refill → no instr_in_valid pulse, IDLE reached after COOL, next request accepted.
- rdy low for 3 cycles during a 4-byte store → no extra mem_wr pulses, correct 4 bytes written, done delayed by 3 cycles. rst mid-read → all outputs zero next cycle, no pulse.
